// File: rtl/fsm_stream_arbiter.sv
// Round-robin front end that lends one serial sequence detector to two requesters,
// shifting the winner's word through it LSB first and returning the match count.
module fsm_stream_arbiter #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] word_a,
    input  logic [WIDTH-1:0] word_b,
    input  logic             fsm_y,
    output logic             fsm_x,
    output logic             fsm_clr,
    output logic             busy,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic [CW-1:0]    match_cnt
);

    // state | meaning
    // IDLE  | no owner, requests arbitrated at each edge
    // CLR   | detector cleared for one cycle
    // SHIFT | owner's word driven onto fsm_x, one bit per cycle
    // DONE  | result valid on match_cnt, done pulse to owner
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int IW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;   // 0 = A, 1 = B
    logic             last_q, last_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    match_q, match_d;
    logic             pick;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        pick    = 1'b0;

        if (req_a && req_b) begin
            pick = ~last_q;
        end else if (req_b) begin
            pick = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_d = pick;
                    last_d  = pick;
                    word_d  = pick ? word_b : word_a;
                    cnt_d   = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                idx_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + CW'(fsm_y);
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(WIDTH - 1)) begin
                    // Load the result now so it is already valid during DONE.
                    match_d = cnt_q + CW'(fsm_y);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign gnt_a     = busy && !owner_q;
    assign gnt_b     = busy && owner_q;
    assign fsm_clr   = (state_q == CLR);
    assign fsm_x     = (state_q == SHIFT) ? word_q[idx_q] : 1'b0;
    assign done_a    = (state_q == DONE) && !owner_q;
    assign done_b    = (state_q == DONE) && owner_q;
    assign match_cnt = match_q;

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// Directed bench for fsm_stream_arbiter with a configurable detector stub.
module tb_fsm_stream_arbiter;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] word_a = 8'h00, word_b = 8'h00;
    logic       fsm_y, fsm_x, fsm_clr, busy, gnt_a, gnt_b, done_a, done_b;
    logic [3:0] match_cnt;

    int stub_mode = 0;   // 0: y = x, 1: y = 0, 2: y = 1
    int passed = 0;
    int total = 0;
    int cyc = 0;
    int last_done = 0;

    assign fsm_y = (stub_mode == 0) ? fsm_x : (stub_mode == 1) ? 1'b0 : 1'b1;

    fsm_stream_arbiter #(.WIDTH(8), .CW(4)) dut (
        .CLK(CLK), .Reset(Reset), .req_a(req_a), .req_b(req_b),
        .word_a(word_a), .word_b(word_b), .fsm_y(fsm_y), .fsm_x(fsm_x),
        .fsm_clr(fsm_clr), .busy(busy), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done_a(done_a), .done_b(done_b), .match_cnt(match_cnt)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       ra;
        logic       rb;
        logic [7:0] wa;
        logic [7:0] wb;
        int         stub;
        logic       own;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d want %0d", name, act, exp);
        else passed++;
    endtask

    task automatic check_quiet(input string tag, input logic [3:0] exp_cnt);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " gnt"}, {30'd0, gnt_a, gnt_b}, 0);
        check({tag, " done"}, {30'd0, done_a, done_b}, 0);
        check({tag, " clr_x"}, {30'd0, fsm_clr, fsm_x}, 0);
        check({tag, " match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    endtask

    // Called in an IDLE cycle with requests already driven; ends in the following IDLE cycle.
    task automatic run_txn(input string tag, input logic [7:0] w, input logic own,
                           input logic [3:0] ecnt, input bit drop, input logic [7:0] new_word);
        tick();
        check({tag, " c1 busy"}, 32'(busy), 1);
        check({tag, " c1 gnt"}, {30'd0, gnt_a, gnt_b}, own ? 32'd1 : 32'd2);
        check({tag, " c1 clr"}, 32'(fsm_clr), 1);
        check({tag, " c1 x"}, 32'(fsm_x), 0);
        if (drop) begin
            req_a = 1'b0;
            req_b = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (drop && i == 1) word_a = new_word;
            check($sformatf("%s shift%0d x", tag, i), 32'(fsm_x), 32'(w[i]));
            check($sformatf("%s shift%0d clr", tag, i), 32'(fsm_clr), 0);
            check($sformatf("%s shift%0d done", tag, i), {30'd0, done_a, done_b}, 0);
        end
        tick();
        check({tag, " done"}, {30'd0, done_a, done_b}, own ? 32'd1 : 32'd2);
        check({tag, " match_cnt"}, 32'(match_cnt), 32'(ecnt));
        check({tag, " done busy"}, 32'(busy), 1);
        last_done = cyc;
        tick();
        check_quiet({tag, " idle"}, ecnt);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'hFF, 8'h00, 0, 1'b0, 4'd8};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'h00, 0, 1'b1, 4'd0};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h00, 0, 1'b0, 4'd8};
        vecs[3] = '{1'b1, 1'b0, 8'hB5, 8'h00, 0, 1'b0, 4'd5};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1, 1'b1, 4'd0};
        vecs[5] = '{1'b1, 1'b0, 8'h96, 8'h00, 2, 1'b0, 4'd8};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 2, 1'b1, 4'd8};

        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) check_quiet($sformatf("reset idle%0d", i), 4'd0);

        for (int i = 0; i < 7; i++) begin
            int prev_done;
            prev_done = last_done;
            req_a = vecs[i].ra;
            req_b = vecs[i].rb;
            word_a = vecs[i].wa;
            word_b = vecs[i].wb;
            stub_mode = vecs[i].stub;
            run_txn($sformatf("vec%0d", i), vecs[i].own ? vecs[i].wb : vecs[i].wa,
                    vecs[i].own, vecs[i].cnt, 1'b0, 8'h00);
            if (i == 1 || i == 2) check($sformatf("vec%0d spacing", i), 32'(last_done - prev_done), 11);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        stub_mode = 0;

        // Reset during the fourth SHIFT cycle of a B transaction.
        tick();
        req_b = 1'b1;
        word_b = 8'h0F;
        tick();
        check("abort c1 gnt_b", 32'(gnt_b), 1);
        req_b = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort shift3 x", 32'(fsm_x), 1);
        Reset = 1'b1;
        tick();
        check_quiet("abort after reset", 4'd0);
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("abort no done_b %0d", i), {30'd0, done_a, done_b}, 0);
        end

        req_a = 1'b1;
        word_a = 8'h01;
        run_txn("post reset A", 8'h01, 1'b0, 4'd1, 1'b1, 8'h01);

        req_a = 1'b1;
        word_a = 8'h81;
        run_txn("drop A", 8'h81, 1'b0, 4'd2, 1'b1, 8'hFF);
        tick();
        check_quiet("final idle", 4'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
